// File: rtl/ex_mem_stage.sv
// ex_mem_stage: EX/MEM pipeline register; resolves branches and overflow traps, feeds mem stage (out_*), fetch redirect (br_*), EPC (exc_*, epc) and forwarding (fwd_*)
module ex_mem_stage #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic          stall,
  input  logic          flush,
  input  logic [DW-1:0] alu_res,
  input  logic          alu_v,
  input  logic          alu_c_out,
  input  logic          alu_zero,
  input  logic [DW-1:0] store_data,
  input  logic [RW-1:0] dest,
  input  logic          ctl_reg_write,
  input  logic          ctl_mem_read,
  input  logic          ctl_mem_write,
  input  logic          ctl_mem_to_reg,
  input  logic          ctl_beq,
  input  logic          ctl_bne,
  input  logic          ctl_trap_ovf,
  input  logic [DW-1:0] br_target,
  input  logic [DW-1:0] pc_in,
  input  logic          exc_ack,
  output logic          out_valid,
  output logic [DW-1:0] out_res,
  output logic [DW-1:0] out_store_data,
  output logic [RW-1:0] out_dest,
  output logic          out_reg_write,
  output logic          out_mem_read,
  output logic          out_mem_write,
  output logic          out_mem_to_reg,
  output logic          out_carry,
  output logic          br_taken,
  output logic [DW-1:0] br_pc,
  output logic          exc_pending,
  output logic [DW-1:0] epc,
  output logic          fwd_en,
  output logic [RW-1:0] fwd_dest,
  output logic [DW-1:0] fwd_data
);
  logic acc, ovf, tk;
  assign acc = in_valid & ~exc_pending;
  assign ovf = acc & ctl_trap_ovf & alu_v;
  assign tk  = acc & ((ctl_beq & alu_zero) | (ctl_bne & ~alu_zero)) & ~ovf;
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid      <= 1'b0;
      out_res        <= '0;
      out_store_data <= '0;
      out_dest       <= '0;
      out_reg_write  <= 1'b0;
      out_mem_read   <= 1'b0;
      out_mem_write  <= 1'b0;
      out_mem_to_reg <= 1'b0;
      out_carry      <= 1'b0;
      br_taken       <= 1'b0;
      br_pc          <= '0;
      exc_pending    <= 1'b0;
      epc            <= '0;
    end else begin
      if (exc_ack) exc_pending <= 1'b0;
      if (flush) begin
        out_valid      <= 1'b0;
        out_reg_write  <= 1'b0;
        out_mem_read   <= 1'b0;
        out_mem_write  <= 1'b0;
        out_mem_to_reg <= 1'b0;
        br_taken       <= 1'b0;
      end else if (stall) begin
        br_taken <= 1'b0;
      end else begin
        out_valid      <= acc;
        out_res        <= alu_res;
        out_store_data <= store_data;
        out_dest       <= dest;
        out_carry      <= alu_c_out;
        out_reg_write  <= acc & ctl_reg_write & ~ovf;
        out_mem_read   <= acc & ctl_mem_read & ~ovf;
        out_mem_write  <= acc & ctl_mem_write & ~ovf;
        out_mem_to_reg <= acc & ctl_mem_to_reg;
        br_taken       <= tk;
        if (tk) br_pc <= br_target;
        if (ovf) begin
          exc_pending <= 1'b1;
          epc         <= pc_in;
        end
      end
    end
  end
  assign fwd_en   = out_valid & out_reg_write & (out_dest != '0);
  assign fwd_dest = out_dest;
  assign fwd_data = out_res;
endmodule

// File: tb/tb_ex_mem_stage.sv
// tb_ex_mem_stage: randomized + directed bench for ex_mem_stage against a behavioural model
module tb_ex_mem_stage;
  localparam int DW = 32;
  localparam int RW = 5;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, in_valid, stall, flush, alu_v, alu_c_out, alu_zero;
  logic [DW-1:0] alu_res, store_data, br_target, pc_in;
  logic [RW-1:0] dest;
  logic ctl_reg_write, ctl_mem_read, ctl_mem_write, ctl_mem_to_reg, ctl_beq, ctl_bne, ctl_trap_ovf, exc_ack;
  logic out_valid, out_reg_write, out_mem_read, out_mem_write, out_mem_to_reg, out_carry;
  logic br_taken, exc_pending, fwd_en;
  logic [DW-1:0] out_res, out_store_data, br_pc, epc, fwd_data;
  logic [RW-1:0] out_dest, fwd_dest;

  ex_mem_stage #(.DW(DW), .RW(RW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .stall(stall), .flush(flush),
    .alu_res(alu_res), .alu_v(alu_v), .alu_c_out(alu_c_out), .alu_zero(alu_zero),
    .store_data(store_data), .dest(dest),
    .ctl_reg_write(ctl_reg_write), .ctl_mem_read(ctl_mem_read), .ctl_mem_write(ctl_mem_write),
    .ctl_mem_to_reg(ctl_mem_to_reg), .ctl_beq(ctl_beq), .ctl_bne(ctl_bne), .ctl_trap_ovf(ctl_trap_ovf),
    .br_target(br_target), .pc_in(pc_in), .exc_ack(exc_ack),
    .out_valid(out_valid), .out_res(out_res), .out_store_data(out_store_data), .out_dest(out_dest),
    .out_reg_write(out_reg_write), .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
    .out_mem_to_reg(out_mem_to_reg), .out_carry(out_carry), .br_taken(br_taken), .br_pc(br_pc),
    .exc_pending(exc_pending), .epc(epc), .fwd_en(fwd_en), .fwd_dest(fwd_dest), .fwd_data(fwd_data)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  bit m_valid, m_rw, m_mr, m_mw, m_m2r, m_carry, m_bt, m_exc, m_known;
  logic [DW-1:0] m_res, m_sd, m_bpc, m_epc;
  logic [RW-1:0] m_dest;

  task automatic check_all();
    chk("out_valid", out_valid, m_valid);
    chk("out_reg_write", out_reg_write, m_rw);
    chk("out_mem_read", out_mem_read, m_mr);
    chk("out_mem_write", out_mem_write, m_mw);
    chk("out_mem_to_reg", out_mem_to_reg, m_m2r);
    chk("br_taken", br_taken, m_bt);
    chk("br_pc", br_pc, m_bpc);
    chk("exc_pending", exc_pending, m_exc);
    chk("epc", epc, m_epc);
    chk("fwd_en", fwd_en, m_valid && m_rw && m_dest != 0);
    if (m_known) begin
      chk("out_res", out_res, m_res);
      chk("out_store_data", out_store_data, m_sd);
      chk("out_dest", out_dest, m_dest);
      chk("out_carry", out_carry, m_carry);
      chk("fwd_dest", fwd_dest, m_dest);
      chk("fwd_data", fwd_data, m_res);
    end
  endtask

  task automatic step();
    bit live, trap, taken, was_pending;
    was_pending = m_exc;
    if (rst) begin
      {m_valid, m_rw, m_mr, m_mw, m_m2r, m_carry, m_bt, m_exc} = '0;
      m_res = 0; m_sd = 0; m_bpc = 0; m_epc = 0; m_dest = 0; m_known = 1;
    end else begin
      if (exc_ack) m_exc = 0;
      if (flush) begin
        {m_valid, m_rw, m_mr, m_mw, m_m2r, m_bt} = '0;
        m_known = 0;
      end else if (stall) begin
        m_bt = 0;
      end else begin
        live  = in_valid && !was_pending;
        trap  = live && ctl_trap_ovf && alu_v;
        taken = live && !trap && ((ctl_beq && alu_zero) || (ctl_bne && !alu_zero));
        m_valid = live;
        m_res = alu_res; m_sd = store_data; m_dest = dest; m_carry = alu_c_out; m_known = 1;
        m_rw  = live && ctl_reg_write && !trap;
        m_mr  = live && ctl_mem_read && !trap;
        m_mw  = live && ctl_mem_write && !trap;
        m_m2r = live && ctl_mem_to_reg;
        m_bt  = taken;
        if (taken) m_bpc = br_target;
        if (trap) begin
          m_exc = 1;
          m_epc = pc_in;
        end
      end
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle();
    {rst, in_valid, stall, flush, alu_v, alu_c_out, alu_zero} = '0;
    {ctl_reg_write, ctl_mem_read, ctl_mem_write, ctl_mem_to_reg, ctl_beq, ctl_bne, ctl_trap_ovf, exc_ack} = '0;
    alu_res = 0; store_data = 0; br_target = 0; pc_in = 0; dest = 0;
  endtask

  initial begin
    idle();
    m_known = 0;
    rst = 1; in_valid = 1; stall = 1; alu_res = 32'hFFFF_0000; ctl_reg_write = 1; dest = 7;
    step();
    chk("rst_res", out_res, 0);
    chk("rst_valid", out_valid, 0);
    idle(); in_valid = 1; alu_res = 5; dest = 3; ctl_reg_write = 1;
    step();
    chk("add_res", out_res, 5);
    chk("add_fwd_en", fwd_en, 1);
    chk("add_fwd_dest", fwd_dest, 3);

    idle(); in_valid = 1; ctl_trap_ovf = 1; alu_v = 1; pc_in = 32'h0040_0010; ctl_reg_write = 1; dest = 4;
    step();
    chk("ovf_rw", out_reg_write, 0);
    chk("ovf_valid", out_valid, 1);
    chk("ovf_epc", epc, 32'h0040_0010);
    idle(); in_valid = 1; ctl_reg_write = 1; dest = 5; alu_res = 9;
    step();
    chk("killed1", out_valid, 0);
    step();
    chk("killed2", out_valid, 0);
    exc_ack = 1;
    step();
    chk("ack_clear", exc_pending, 0);
    exc_ack = 0;
    step();
    chk("after_ack", out_valid, 1);
    idle(); in_valid = 1; alu_v = 1; ctl_reg_write = 1; dest = 6;
    step();
    chk("addu_rw", out_reg_write, 1);
    chk("addu_exc", exc_pending, 0);

    idle(); in_valid = 1; ctl_beq = 1; alu_zero = 1; br_target = 32'h0040_0100;
    step();
    chk("beq_taken", br_taken, 1);
    chk("beq_pc", br_pc, 32'h0040_0100);
    idle();
    step();
    chk("beq_pulse", br_taken, 0);
    in_valid = 1; ctl_bne = 1; alu_zero = 1; br_target = 32'h0040_0200;
    step();
    chk("bne_not", br_taken, 0);
    idle(); in_valid = 1; ctl_beq = 1; alu_zero = 1; br_target = 32'h0040_0300;
    step();
    stall = 1;
    step();
    chk("beq_stall", br_taken, 0);
    step();

    idle(); in_valid = 1; alu_res = 32'hDEAD_BEEF; ctl_reg_write = 1; dest = 8;
    step();
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      alu_res = $urandom; dest = 5'($urandom);
      step();
    end
    chk("stall_hold", out_res, 32'hDEAD_BEEF);
    flush = 1;
    step();
    chk("flush_valid", out_valid, 0);
    chk("flush_rw", out_reg_write, 0);

    idle(); in_valid = 1; dest = 0; ctl_reg_write = 1; alu_res = 77;
    step();
    chk("r0_fwd", fwd_en, 0);
    chk("r0_rw", out_reg_write, 1);
    idle(); in_valid = 1; ctl_mem_write = 1; store_data = 32'h1234_5678;
    step();
    chk("store_data", out_store_data, 32'h1234_5678);
    chk("store_fwd", fwd_en, 0);

    idle(); in_valid = 1; ctl_trap_ovf = 1; alu_v = 1; pc_in = 32'h0040_0030;
    step();
    exc_ack = 1; pc_in = 32'h0040_0020;
    step();
    chk("simul_exc", exc_pending, 0);
    chk("simul_epc", epc, 32'h0040_0030);
    chk("simul_valid", out_valid, 0);

    for (int i = 0; i < 500; i++) begin
      rst = ($urandom_range(63) == 0);
      stall = ($urandom_range(4) == 0);
      flush = ($urandom_range(7) == 0);
      exc_ack = ($urandom_range(5) == 0);
      in_valid = ($urandom_range(3) != 0);
      ctl_trap_ovf = $urandom_range(1);
      alu_v = ($urandom_range(3) == 0);
      alu_zero = $urandom_range(1);
      alu_c_out = $urandom_range(1);
      ctl_beq = ($urandom_range(3) == 0);
      ctl_bne = ($urandom_range(3) == 0);
      ctl_reg_write = $urandom_range(1);
      ctl_mem_read = $urandom_range(1);
      ctl_mem_write = $urandom_range(1);
      ctl_mem_to_reg = $urandom_range(1);
      alu_res = $urandom; store_data = $urandom; br_target = $urandom; pc_in = $urandom;
      dest = 5'($urandom_range(3) == 0 ? 0 : $urandom);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
Pipeline register and resolution stage directly downstream of the execute ALU. Captures the ALU result, flags (v, c_out, zero), store data and control bits each cycle. Resolves conditional branches from the zero flag and raises a precise overflow exception. Presents registered values to the memory stage and a forwarding tap back to execute.

Parameters:
DW, 32, datapath width (ALU result, store data, PC)
RW, 5, register-address width

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
in_valid  input  1  execute holds a live instruction
stall  input  1  hold all registered state (memory stage busy)
flush  input  1  kill the incoming instruction (younger-than-branch or exception)
alu_res  input  DW  ALU result
alu_v  input  1  ALU signed overflow
alu_c_out  input  1  ALU carry out
alu_zero  input  1  ALU zero flag
store_data  input  DW  rt value for stores
dest  input  RW  destination register
ctl_reg_write, ctl_mem_read, ctl_mem_write, ctl_mem_to_reg  input  1 each  control bits
ctl_beq, ctl_bne  input  1 each  branch type
ctl_trap_ovf  input  1  trap on overflow (add/sub vs addu/subu)
br_target  input  DW  computed branch target
pc_in  input  DW  PC of the execute instruction
exc_ack  input  1  exception handler has taken EPC
out_valid  output  1  registered valid
out_res, out_store_data  output  DW  registered
out_dest  output  RW  registered
out_reg_write, out_mem_read, out_mem_write, out_mem_to_reg  output  1 each  registered, gated by validity
out_carry  output  1  registered alu_c_out
br_taken  output  1  one-cycle pulse: redirect fetch
br_pc  output  DW  redirect target
exc_pending  output  1  sticky overflow exception
epc  output  DW  PC of the faulting instruction
fwd_en  output  1  out_valid & out_reg_write & (out_dest != 0)
fwd_dest  output  RW  equals out_dest
fwd_data  output  DW  equals out_res

Behaviour:
- Reset (synchronous, on rst=1 at a clk edge): all outputs 0, including epc, br_pc and exc_pending. rst overrides stall and flush. A reset mid-instruction discards it.
- Latency: 1 cycle. Inputs sampled at edge N appear on outputs after edge N.
- Priority at each edge: rst > flush > stall > capture.
- flush=1: out_valid<=0, all out_ctl<=0, br_taken<=0. Data registers may load but must not be used. flush overrides a simultaneous stall.
- stall=1 (no flush): every register holds, except br_taken, which clears to 0 so it never pulses twice.
- Capture (no stall, no flush): acc = in_valid & ~exc_pending.
  - out_valid<=acc.
  - Data fields load unconditionally.
  - Control bits load ANDed with acc.
- Overflow trap: ovf = acc & ctl_trap_ovf & alu_v. When ovf at a capture edge:
  - out_reg_write, out_mem_read and out_mem_write forced 0; out_valid stays 1.
  - exc_pending<=1 and epc<=pc_in.
  - br_taken<=0 even if the instruction is a branch.
- exc_pending is sticky until exc_ack=1 at an edge, which clears it. exc_ack with no pending exception is a no-op.
  - While pending, every following capture is killed (acc=0).
  - A new overflow cannot overwrite epc.
  - If exc_ack and a new ovf occur at the same edge: the ovf is suppressed, because acc is computed from the pre-edge exc_pending.
- Branch: tk = acc & ((ctl_beq & alu_zero) | (ctl_bne & ~alu_zero)) & ~ovf.
  - br_taken<=tk.
  - br_pc<=br_target only when tk=1, otherwise it holds.
  - br_taken is high for exactly one cycle per taken branch.
  - ctl_beq and ctl_bne both set is illegal; the required result is br_taken = ctl_beq&zero | ctl_bne&~zero, which is always 1 when both are set.
- Forwarding: fwd_* is combinational from registered outputs only, with no path from the inputs. Writes to r0 are never forwarded.
- Widths: all fields are passed through unmodified. No extension or truncation.

Test Plan:
1. Reset: hold rst=1 with in_valid=1 and stall=1 -> after the edge, all outputs 0. Release rst, apply add res=0x00000005, dest=3, reg_write=1 -> next cycle out_valid=1, out_res=5, fwd_en=1, fwd_dest=3.
2. Overflow trap: trap_ovf=1, alu_v=1, pc_in=0x00400010, reg_write=1 -> out_reg_write=0, exc_pending=1, epc=0x00400010. The next two valid instructions give out_valid=0. exc_ack=1 -> exc_pending=0, and the next instruction is captured. With ctl_trap_ovf=0 (addu) and alu_v=1 -> no exception, out_reg_write=1.
3. Branches:
   - beq, zero=1, br_target=0x00400100 -> br_taken=1 for one cycle, br_pc=0x00400100.
   - bne, zero=1 -> br_taken=0.
   - beq taken with stall=1 on the following cycle -> br_taken is 1 for exactly one cycle.
4. Stall/flush: load res=0xDEADBEEF, then stall for 3 cycles while inputs change -> outputs hold 0xDEADBEEF. stall=1 and flush=1 together -> out_valid=0 and all out_ctl=0.
5. Forward to r0: dest=0, reg_write=1 -> fwd_en=0 while out_reg_write=1. A mem_write store with store_data=0x12345678 -> out_store_data=0x12345678 and fwd_en=0.
6. Simultaneous ack and overflow: with exc_pending=1, assert exc_ack together with a new overflow instruction at pc 0x00400020 -> exc_pending=0, epc unchanged, out_valid=0.
